ga_front_end: RTL and testbench

Front end of the genetic path-search engine. Bundles three independent functions:
- **Button pulser:** turns the run button into a one-cycle start pulse for the state controller.
- **Initial-population generator:** fills 50 individuals of 150 bits from a seeded PRNG.
- **Selector:** scores a 50-individual population and returns the 10 fittest individuals to the mutation stage.

---
 rtl/ga_pkg.sv | 45 ++++
 rtl/ga_if.sv | 31 +++
 rtl/button_pulser.sv | 39 +++
 rtl/xorshift32.sv | 20 ++
 rtl/ga_front_end.sv | 182 ++++++++++++++++++
 tb/tb_ga_front_end.sv | 265 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/ga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ga_pkg                                                                   |
// | Shared sizes, move encoding, FSM state types and individual helpers for  |
// | the genetic path-search front end.                                       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package ga_pkg;
  localparam int POP_N  = 50;            // individuals per population
  localparam int IND_W  = 150;           // bits per individual (75 moves)
  localparam int SEL_N  = 10;            // individuals kept by selection
  localparam int POP_W  = POP_N * IND_W;
  localparam int SELP_W = SEL_N * IND_W;
  localparam int FIT_W  = 7;             // fitness range 0..75
  localparam int IDX_W  = 6;

  localparam logic [1:0]       MOVE_FWD   = 2'b01;
  localparam logic [31:0]      PRNG_RESET = 32'h1;
  localparam logic [7:0]       FILL_LAST  = 8'd234;  // 235 words per fill
  localparam logic [IDX_W-1:0] IDX_LAST   = 6'd49;
  localparam logic [3:0]       RANK_LAST  = 4'd9;

  typedef logic [IND_W-1:0] ind_t;
  typedef logic [FIT_W-1:0] fit_t;

  typedef enum logic [1:0] {G_IDLE, G_FILL, G_DONE} gen_state_t;
  typedef enum logic [1:0] {S_IDLE, S_SCORE, S_PICK, S_DONE} sel_state_t;

  // Individual i of a flat population vector.
  function automatic ind_t ind_slice(input logic [POP_W-1:0] p,
                                     input logic [IDX_W-1:0] i);
    return p[i*IND_W +: IND_W];
  endfunction

  // Number of forward moves in an individual.
  function automatic fit_t fitness(input ind_t ind);
    fit_t f;
    f = '0;
    for (int m = 0; m < IND_W/2; m++) begin
      if (ind[2*m +: 2] == MOVE_FWD) f = f + 1'b1;
    end
    return f;
  endfunction
endpackage
`default_nettype wire

// File: rtl/ga_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ga_if                                                                    |
// | Bundles the front-end control and data signals.                          |
// | master: drives button, init_start, prg_seed, sel_start, pop.             |
// | slave : drives button_p, init_population, init_done, sel_pop, sel_done.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface ga_if;
  import ga_pkg::*;
  logic              button;
  logic              button_p;
  logic              init_start;
  logic [31:0]       prg_seed;
  logic [POP_W-1:0]  init_population;
  logic              init_done;
  logic              sel_start;
  logic [POP_W-1:0]  pop;
  logic [SELP_W-1:0] sel_pop;
  logic              sel_done;

  modport master (
    output button, init_start, prg_seed, sel_start, pop,
    input  button_p, init_population, init_done, sel_pop, sel_done
  );
  modport slave (
    input  button, init_start, prg_seed, sel_start, pop,
    output button_p, init_population, init_done, sel_pop, sel_done
  );
endinterface
`default_nettype wire

// File: rtl/button_pulser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_pulser                                                            |
// | Two-flop synchronizer plus rising-edge detector for the run button.      |
// | Ports: clk, rst_n, button (async raw in), button_p (one-cycle pulse out) |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module button_pulser (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic button_p
);
  logic sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, pulse_q, pulse_d;

  always_comb begin
    sync1_d = button;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pulse_d = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign button_p = pulse_q;
endmodule
`default_nettype wire

// File: rtl/xorshift32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | xorshift32                                                               |
// | One combinational xorshift32 step (13, 17, 5).                           |
// | Ports: x (current state in), y (next state out)                          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module xorshift32 (
  input  logic [31:0] x,
  output logic [31:0] y
);
  logic [31:0] w_a, w_b;

  always_comb begin
    w_a = x ^ (x << 13);
    w_b = w_a ^ (w_a >> 17);
    y   = w_b ^ (w_b << 5);
  end
endmodule
`default_nettype wire

// File: rtl/ga_front_end.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ga_front_end                                                             |
// | Button pulser, seeded initial-population generator and top-10 selector.  |
// | Ports: clk, rst_n (async active-low), bus (ga_if.slave: button/button_p, |
// |        init_start/prg_seed/init_population/init_done,                    |
// |        sel_start/pop/sel_pop/sel_done)                                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module ga_front_end (
  input logic  clk,
  input logic  rst_n,
  ga_if.slave  bus
);
  import ga_pkg::*;

  button_pulser u_pulser (
    .clk      (clk),
    .rst_n    (rst_n),
    .button   (bus.button),
    .button_p (bus.button_p)
  );

  // ---------------- Generator ----------------
  gen_state_t       gen_state_q, gen_state_d;
  logic [31:0]      prng_q, prng_d, w_prng_next;
  logic [7:0]       fill_cnt_q, fill_cnt_d;
  logic [POP_W-1:0] init_pop_q, init_pop_d;
  logic             init_done_q, init_done_d;

  xorshift32 u_prng (.x(prng_q), .y(w_prng_next));

  always_comb begin
    gen_state_d = gen_state_q;
    prng_d      = prng_q;
    fill_cnt_d  = fill_cnt_q;
    init_pop_d  = init_pop_q;
    init_done_d = 1'b0;
    case (gen_state_q)
      G_IDLE: if (bus.init_start) begin
        // A zero seed would lock xorshift at zero forever.
        prng_d      = (bus.prg_seed == 32'h0) ? PRNG_RESET : bus.prg_seed;
        fill_cnt_d  = '0;
        gen_state_d = G_FILL;
      end
      G_FILL: begin
        prng_d     = w_prng_next;
        init_pop_d = {w_prng_next, init_pop_q[POP_W-1:32]};
        fill_cnt_d = fill_cnt_q + 8'd1;
        if (fill_cnt_q == FILL_LAST) gen_state_d = G_DONE;
      end
      G_DONE: begin
        init_done_d = 1'b1;
        gen_state_d = G_IDLE;
      end
      default: gen_state_d = G_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_state_q <= G_IDLE;
      prng_q      <= PRNG_RESET;
      fill_cnt_q  <= '0;
      init_pop_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      gen_state_q <= gen_state_d;
      prng_q      <= prng_d;
      fill_cnt_q  <= fill_cnt_d;
      init_pop_q  <= init_pop_d;
      init_done_q <= init_done_d;
    end
  end

  assign bus.init_population = init_pop_q;
  assign bus.init_done       = init_done_q;

  // ---------------- Selector ----------------
  sel_state_t             sel_state_q, sel_state_d;
  logic [POP_W-1:0]       pop_q, pop_d;
  logic [POP_N*FIT_W-1:0] scores_q, scores_d;
  logic [POP_N-1:0]       taken_q, taken_d;
  logic [IDX_W-1:0]       idx_q, idx_d, best_q, best_d, w_win;
  fit_t                   best_score_q, best_score_d, w_cur_score;
  logic                   best_vld_q, best_vld_d, w_cand_better;
  logic [3:0]             rank_q, rank_d;
  logic [SELP_W-1:0]      sel_pop_q, sel_pop_d;
  logic                   sel_done_q, sel_done_d;

  always_comb begin
    sel_state_d  = sel_state_q;
    pop_d        = pop_q;
    scores_d     = scores_q;
    taken_d      = taken_q;
    idx_d        = idx_q;
    best_d       = best_q;
    best_score_d = best_score_q;
    best_vld_d   = best_vld_q;
    rank_d       = rank_q;
    sel_pop_d    = sel_pop_q;
    sel_done_d   = 1'b0;
    w_cur_score  = scores_q[idx_q*FIT_W +: FIT_W];
    // Strict compare keeps the earliest index on ties.
    w_cand_better = ~taken_q[idx_q] & (~best_vld_q | (w_cur_score > best_score_q));
    w_win         = w_cand_better ? idx_q : best_q;
    case (sel_state_q)
      S_IDLE: if (bus.sel_start) begin
        pop_d       = bus.pop;
        taken_d     = '0;
        idx_d       = '0;
        rank_d      = '0;
        best_vld_d  = 1'b0;
        sel_state_d = S_SCORE;
      end
      S_SCORE: begin
        scores_d[idx_q*FIT_W +: FIT_W] = fitness(ind_slice(pop_q, idx_q));
        if (idx_q == IDX_LAST) begin
          idx_d       = '0;
          sel_state_d = S_PICK;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      S_PICK: begin
        if (idx_q == IDX_LAST) begin
          // Last index of the round: commit the winner including this candidate.
          sel_pop_d[rank_q*IND_W +: IND_W] = ind_slice(pop_q, w_win);
          taken_d[w_win] = 1'b1;
          best_vld_d     = 1'b0;
          idx_d          = '0;
          rank_d         = rank_q + 4'd1;
          if (rank_q == RANK_LAST) sel_state_d = S_DONE;
        end else begin
          idx_d = idx_q + 6'd1;
          if (w_cand_better) begin
            best_d       = idx_q;
            best_score_d = w_cur_score;
            best_vld_d   = 1'b1;
          end
        end
      end
      S_DONE: begin
        sel_done_d  = 1'b1;
        sel_state_d = S_IDLE;
      end
      default: sel_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_state_q  <= S_IDLE;
      pop_q        <= '0;
      scores_q     <= '0;
      taken_q      <= '0;
      idx_q        <= '0;
      best_q       <= '0;
      best_score_q <= '0;
      best_vld_q   <= 1'b0;
      rank_q       <= '0;
      sel_pop_q    <= '0;
      sel_done_q   <= 1'b0;
    end else begin
      sel_state_q  <= sel_state_d;
      pop_q        <= pop_d;
      scores_q     <= scores_d;
      taken_q      <= taken_d;
      idx_q        <= idx_d;
      best_q       <= best_d;
      best_score_q <= best_score_d;
      best_vld_q   <= best_vld_d;
      rank_q       <= rank_d;
      sel_pop_q    <= sel_pop_d;
      sel_done_q   <= sel_done_d;
    end
  end

  assign bus.sel_pop  = sel_pop_q;
  assign bus.sel_done = sel_done_q;
endmodule
`default_nettype wire

// File: tb/tb_ga_front_end.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ga_front_end                                                          |
// | Scoreboard bench: stimulus pushes expected results and their arrival     |
// | cycle; a monitor pops and compares on every done/pulse output.           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ga_front_end;
  import ga_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ga_if bus ();

  ga_front_end dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [POP_W-1:0] data; int cyc; } gen_exp_t;
  typedef struct { logic [SELP_W-1:0] data; int cyc; } sel_exp_t;
  gen_exp_t gen_q[$];
  sel_exp_t sel_q[$];
  int       btn_q[$];

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_wide(input string name, input logic [POP_W-1:0] act,
                          input logic [POP_W-1:0] exp, input int nslices);
    int bad;
    bad = -1;
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      for (int i = 0; i < nslices; i++)
        if (bad < 0 && act[i*IND_W +: IND_W] !== exp[i*IND_W +: IND_W]) bad = i;
      if (bad < 0) bad = 0;
      $display("FAIL %s: slice %0d got %h expected %h", name, bad,
               act[bad*IND_W +: IND_W], exp[bad*IND_W +: IND_W]);
    end
  endtask

  function automatic logic [31:0] xs(input logic [31:0] v);
    v ^= v << 13;
    v ^= v >> 17;
    v ^= v << 5;
    return v;
  endfunction

  // Individual with `score` forward moves at the bottom and a 6-bit tag
  // encoded as moves 2'b1x at positions 64..69 (tags never score).
  function automatic ind_t mk_ind(input int score, input int tag);
    ind_t v;
    v = '0;
    for (int m = 0; m < score; m++) v[2*m +: 2] = 2'b01;
    for (int m = 0; m < 6; m++) v[2*(64+m) +: 2] = {1'b1, tag[m]};
    return v;
  endfunction

  // ---------------- Monitor ----------------
  initial forever begin
    @(negedge clk);
    if (bus.init_done === 1'b1) begin
      if (gen_q.size() == 0) chk_val("init_done_unexpected", 32'd1, 32'd0);
      else begin
        gen_exp_t e;
        e = gen_q.pop_front();
        chk_val("init_done_cycle", cyc, e.cyc);
        chk_wide("init_population", bus.init_population, e.data, POP_N);
      end
    end
    if (bus.sel_done === 1'b1) begin
      if (sel_q.size() == 0) chk_val("sel_done_unexpected", 32'd1, 32'd0);
      else begin
        sel_exp_t e;
        logic [POP_W-1:0] a, x;
        e = sel_q.pop_front();
        a = '0; x = '0;
        a[SELP_W-1:0] = bus.sel_pop;
        x[SELP_W-1:0] = e.data;
        chk_val("sel_done_cycle", cyc, e.cyc);
        chk_wide("sel_pop", a, x, SEL_N);
      end
    end
    if (bus.button_p === 1'b1) begin
      if (btn_q.size() == 0) chk_val("button_p_unexpected", 32'd1, 32'd0);
      else chk_val("button_p_cycle", cyc, btn_q.pop_front());
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic chk_outputs_zero(input string tag);
    chk_val({tag, "_button_p"}, {31'b0, bus.button_p}, 32'd0);
    chk_val({tag, "_init_done"}, {31'b0, bus.init_done}, 32'd0);
    chk_val({tag, "_sel_done"}, {31'b0, bus.sel_done}, 32'd0);
    chk_val({tag, "_init_pop_nonzero"}, {31'b0, |bus.init_population}, 32'd0);
    chk_val({tag, "_sel_pop_nonzero"}, {31'b0, |bus.sel_pop}, 32'd0);
  endtask

  task automatic wait_gen(input int budget);
    int n;
    n = 0;
    while (gen_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    chk_val("init_done_timeout", gen_q.size(), 32'd0);
    gen_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_sel(input int budget);
    int n;
    n = 0;
    while (sel_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    chk_val("sel_done_timeout", sel_q.size(), 32'd0);
    sel_q.delete();
    repeat (2) @(negedge clk);
  endtask

  // Issue a generation; the expected population is built from the PRNG
  // recurrence. With hand_chk the first two words are also checked directly.
  task automatic run_gen(input logic [31:0] seed, input bit hand_chk, input bit wait_done);
    gen_exp_t e;
    logic [31:0] x;
    x = (seed == 32'h0) ? 32'h1 : seed;
    e.data = '0;
    for (int i = 0; i < 235; i++) begin
      x = xs(x);
      e.data = {x, e.data[POP_W-1:32]};
    end
    @(negedge clk);
    bus.prg_seed   = seed;
    bus.init_start = 1'b1;
    e.cyc = cyc + 1 + 236;
    gen_q.push_back(e);
    @(negedge clk);
    bus.init_start = 1'b0;
    if (hand_chk) begin
      @(negedge clk);
      chk_val("gen_word1_top", bus.init_population[POP_W-1 -: 32], 32'h00042021);
      @(negedge clk);
      chk_val("gen_word2_top", bus.init_population[POP_W-1 -: 32], 32'h04080601);
      chk_val("gen_word1_shifted", bus.init_population[POP_W-33 -: 32], 32'h00042021);
    end
    if (wait_done) wait_gen(400);
  endtask

  task automatic run_sel(input logic [POP_W-1:0] p, input logic [SELP_W-1:0] exp,
                         input bit poke, input logic [POP_W-1:0] p2);
    sel_exp_t e;
    @(negedge clk);
    bus.pop       = p;
    bus.sel_start = 1'b1;
    e.data = exp;
    e.cyc  = cyc + 1 + 551;
    sel_q.push_back(e);
    @(negedge clk);
    bus.sel_start = 1'b0;
    if (poke) begin
      // Lands in PICK: must be ignored and the latched pop must be used.
      repeat (100) @(negedge clk);
      bus.pop       = p2;
      bus.sel_start = 1'b1;
      @(negedge clk);
      bus.sel_start = 1'b0;
    end
    wait_sel(800);
  endtask

  // ---------------- Main sequence ----------------
  logic [POP_W-1:0]  ord_pop, tie_pop, mix_pop;
  logic [SELP_W-1:0] ord_exp, tie_exp, mix_exp;
  int                mix_rank [SEL_N];
  int                mix_score [SEL_N];

  initial begin
    bus.button = 1'b0; bus.init_start = 1'b0; bus.sel_start = 1'b0;
    bus.prg_seed = '0; bus.pop = '0;

    // Ascending scores: individual i has i forward moves.
    for (int i = 0; i < POP_N; i++) begin
      ord_pop[i*IND_W +: IND_W] = mk_ind(i, i);
      tie_pop[i*IND_W +: IND_W] = mk_ind(0, i);
      mix_pop[i*IND_W +: IND_W] = mk_ind(0, i);
    end
    mix_pop[45*IND_W +: IND_W] = mk_ind(9, 45);
    mix_pop[3*IND_W +: IND_W]  = mk_ind(5, 3);
    mix_pop[12*IND_W +: IND_W] = mk_ind(5, 12);
    mix_pop[30*IND_W +: IND_W] = mk_ind(5, 30);
    mix_rank  = '{45, 3, 12, 30, 0, 1, 2, 4, 5, 6};
    mix_score = '{9, 5, 5, 5, 0, 0, 0, 0, 0, 0};
    for (int k = 0; k < SEL_N; k++) begin
      ord_exp[k*IND_W +: IND_W] = mk_ind(49 - k, 49 - k);
      tie_exp[k*IND_W +: IND_W] = mk_ind(0, k);
      mix_exp[k*IND_W +: IND_W] = mk_ind(mix_score[k], mix_rank[k]);
    end

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Button: long press gives one pulse, second press gives another.
    bus.button = 1'b1;
    btn_q.push_back(cyc + 3);
    repeat (20) @(negedge clk);
    bus.button = 1'b0;
    repeat (5) @(negedge clk);
    bus.button = 1'b1;
    btn_q.push_back(cyc + 3);
    repeat (6) @(negedge clk);
    bus.button = 1'b0;
    repeat (6) @(negedge clk);
    chk_val("button_pulses_pending", btn_q.size(), 32'd0);

    // Generator.
    run_gen(32'h1, 1'b1, 1'b1);
    run_gen(32'h0, 1'b0, 1'b1);
    run_gen(32'hDEADBEEF, 1'b0, 1'b1);

    // Reset mid-FILL aborts and clears everything.
    run_gen(32'h5, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    gen_q.delete();
    #1;
    chk_outputs_zero("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    run_gen(32'h1, 1'b1, 1'b1);

    // Selector.
    run_sel(ord_pop, ord_exp, 1'b0, '0);
    run_sel(tie_pop, tie_exp, 1'b0, '0);
    run_sel(mix_pop, mix_exp, 1'b0, '0);
    run_sel(ord_pop, ord_exp, 1'b1, tie_pop);

    repeat (20) @(negedge clk);
    chk_val("pending_gen", gen_q.size(), 32'd0);
    chk_val("pending_sel", sel_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
